imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RV immediate generator: decodes the instruction format and immediate at the input,
// then passes each result through a two-entry output buffer (main + skid) with valid/ready flow control.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
  } res_t;

  res_t             dec;
  logic [31:0]      imm32;
  logic [6:0]       opc;
  logic [2:0]       funct3;
  logic             is_shift;

  res_t             main_q, main_d, skid_q, skid_d;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, pop;

  assign opc      = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Every immediate is first built as a 32-bit sign-extended value, then widened to XLEN.
  // Shift amounts have a zero top bit, so the same widening leaves them zero-extended.
  always_comb begin
    imm32   = '0;
    dec.fmt = FMT_ILL;
    unique case (opc)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0010011: begin
        if (is_shift) begin
          dec.fmt = FMT_SHAMT;
          imm32   = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
        end else begin
          dec.fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0011011: begin
        if (is_shift) begin
          dec.fmt = FMT_SHAMT;
          imm32   = {27'b0, in_instr[24:20]};
        end else begin
          dec.fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: dec.fmt = FMT_R;
      default:                dec.fmt = FMT_ILL;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  // Handshake: a transfer happens on a rising edge whenever valid and ready are both high
  // in the preceding cycle; in_ready depends only on the skid flop, never on out_ready.
  assign accept = in_valid && in_ready;
  assign pop    = main_v_q && out_ready;

  // accept implies the skid is empty, so a pop with skid data never coincides with an accept.
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;
    if (pop) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_v_q) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end else begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
    end
    if (accept && (dec.fmt == FMT_ILL) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready      = ~skid_v_q;
  assign out_valid     = main_v_q;
  assign out_imm       = main_q.imm;
  assign out_fmt       = main_q.fmt;
  assign out_illegal   = (main_q.fmt == FMT_ILL);
  assign illegal_count = cnt_q;

endmodule
